fetch_redirect_unit: RTL and testbench



---
 rtl/fetch_redirect_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
//   Fetch-PC sequencer. Issues one instruction-memory request at a time (req/ack),
//   buffers the returned word for decode (valid/ready), and on a branch-unit redirect
//   loads the new target, squashes in-flight/buffered work and pulses a flush.
//
// Ports
//   clk_in, rst_n_in         clock, synchronous active-low reset
//   pc_src_in                redirect request
//   branch_target_in         redirect target (low two bits ignored)
//   stall_in                 blocks launching a new fetch
//   imem_req_out/addr_out    fetch request and address
//   imem_ack_in/rdata_in     memory accept and returned instruction
//   instr_valid_out/out/pc_out, instr_ready_in   decode-side handshake
//   flush_out                one-cycle pulse after each redirect
//   misalign_out             only with FETCH_MISALIGN_TRAP_EN: redirect target was misaligned
//
// Build option: define FETCH_MISALIGN_TRAP_EN to add misalign_out.
module fetch_redirect_unit #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   pc_src_in,
    input  logic [ADDR_WIDTH-1:0]  branch_target_in,
    input  logic                   stall_in,
    output logic                   imem_req_out,
    output logic [ADDR_WIDTH-1:0]  imem_addr_out,
    input  logic                   imem_ack_in,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
    output logic                   instr_valid_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc_out,
    input  logic                   instr_ready_in,
    output logic                   flush_out
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                   misalign_out
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_req;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_instr_pc;
    logic                   r_flush;

    logic [1:0]             w_state_d;
    logic [ADDR_WIDTH-1:0]  w_pc_d;
    logic                   w_capture;
    logic [ADDR_WIDTH-1:0]  w_target;
    logic [1:0]             w_launch_state;

    assign w_target       = {branch_target_in[ADDR_WIDTH-1:2], 2'b00};
    // Where the block goes once it is free to start a fetch.
    assign w_launch_state = stall_in ? ST_IDLE : ST_REQ;

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pc_src_in) begin
                    w_pc_d    = w_target;
                    w_state_d = w_launch_state;
                end else if (!stall_in) begin
                    w_state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (pc_src_in) begin
                    w_pc_d = w_target;
                    // An unacked request cannot be withdrawn; wait it out in SQUASH.
                    w_state_d = imem_ack_in ? w_launch_state : ST_SQUASH;
                end else if (imem_ack_in) begin
                    w_capture = 1'b1;
                    w_pc_d    = r_pc + PC_STEP;
                    w_state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_src_in) begin
                    w_pc_d    = w_target;
                    w_state_d = w_launch_state;
                end else if (instr_ready_in) begin
                    w_state_d = w_launch_state;
                end
            end
            default: begin // ST_SQUASH
                if (pc_src_in) begin
                    w_pc_d = w_target;
                end
                // The squashed request completing frees us to fetch the newest target.
                if (imem_ack_in) begin
                    w_state_d = w_launch_state;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= RESET_PC;
            r_flush    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_req   <= (w_state_d == ST_REQ) || (w_state_d == ST_SQUASH);
            // SQUASH keeps presenting the old address, so only REQ loads a new one.
            if (w_state_d == ST_REQ) begin
                r_addr <= w_pc_d;
            end
            r_valid <= (w_state_d == ST_HOLD);
            if (w_capture) begin
                r_instr    <= imem_rdata_in;
                r_instr_pc <= r_pc;
            end
            r_flush <= pc_src_in;
        end
    end

    assign imem_req_out    = r_req;
    assign imem_addr_out   = r_addr;
    assign instr_valid_out = r_valid;
    assign instr_out       = r_instr;
    assign instr_pc_out    = r_instr_pc;
    assign flush_out       = r_flush;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= pc_src_in && (branch_target_in[1:0] != 2'b00);
        end
    end

    assign misalign_out = r_misalign;
`else
    // Low target bits are dropped when the trap is not built in.
    logic w_unused_target_lsbs;
    assign w_unused_target_lsbs = ^branch_target_in[1:0];
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] tgt;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ready;
    logic        flush;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .pc_src_in        (pc_src),
        .branch_target_in (tgt),
        .stall_in         (stall),
        .imem_req_out     (req),
        .imem_addr_out    (addr),
        .imem_ack_in      (ack),
        .imem_rdata_in    (rdata),
        .instr_valid_out  (valid),
        .instr_out        (instr),
        .instr_pc_out     (instr_pc),
        .instr_ready_in   (ready),
        .flush_out        (flush)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_out     (misalign)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_src = 1'b0; tgt = '0; stall = 1'b0;
        ack = 1'b0; rdata = '0; ready = 1'b1;
        step(); step();
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %h want 0", req); end
        n_tests++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", valid); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
        n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", instr_pc); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %h want 0", flush); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %h want 0", misalign); end
`endif
        rst_n = 1'b1;
        step();
        n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL first_req got %h want 1", req); end
    endtask

    // Zero-wait memory, decode always ready: fetches at 0x0, 0x4, 0x8.
    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (req !== 1'b1 || addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL seq_req%0d got req=%h addr=%h want 1/%h", k, req, addr, 4 * k); end
            ack = 1'b1; rdata = 32'hA000_0000 + 32'(4 * k);
            step();
            ack = 1'b0;
            n_tests++; if (valid !== 1'b1 || instr !== 32'hA000_0000 + 32'(4 * k)
                           || instr_pc !== 32'(4 * k) || req !== 1'b0) begin
                n_fail++; $display("FAIL seq_hold%0d got v=%h i=%h pc=%h req=%h", k, valid, instr, instr_pc, req); end
            step();
            n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL seq_gap%0d got valid=%h want 0", k, valid); end
        end
    endtask

    // Ack arrives after 3 wait cycles; decode back-pressures for one cycle.
    task automatic test_ack_delay();
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (req !== 1'b1 || addr !== 32'hC || valid !== 1'b0) begin
                n_fail++; $display("FAIL delay_wait%0d got req=%h addr=%h v=%h want 1/c/0", k, req, addr, valid); end
        end
        ack = 1'b1; rdata = 32'h1111_000C; ready = 1'b0;
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b1 || instr !== 32'h1111_000C || instr_pc !== 32'hC) begin
            n_fail++; $display("FAIL delay_data got v=%h i=%h pc=%h want 1/1111000c/c", valid, instr, instr_pc); end
        step();
        n_tests++; if (valid !== 1'b1 || req !== 1'b0) begin
            n_fail++; $display("FAIL backpressure got v=%h req=%h want 1/0", valid, req); end
        ready = 1'b1;
    endtask

    // Redirect from HOLD with ready=1 to misaligned 0x103: buffered word dropped, fetch at 0x100.
    task automatic test_redirect_hold();
        pc_src = 1'b1; tgt = 32'h103;
        step();
        pc_src = 1'b0;
        n_tests++; if (flush !== 1'b1 || valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_hold got f=%h v=%h req=%h addr=%h want 1/0/1/100", flush, valid, req, addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_set got %h want 1", misalign); end
`endif
        step();
        n_tests++; if (flush !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_hold2 got f=%h req=%h addr=%h want 0/1/100", flush, req, addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clr got %h want 0", misalign); end
`endif
        ack = 1'b1; rdata = 32'h2222_0100;
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h2222_0100) begin
            n_fail++; $display("FAIL redir_fetch got v=%h pc=%h i=%h want 1/100/22220100", valid, instr_pc, instr); end
        step();
        n_tests++; if (req !== 1'b1 || addr !== 32'h104) begin
            n_fail++; $display("FAIL redir_next got req=%h addr=%h want 1/104", req, addr); end
    endtask

    // Redirect to 0x200 with request outstanding at 0x104, re-redirect to 0x300 in SQUASH.
    task automatic test_redirect_squash();
        pc_src = 1'b1; tgt = 32'h200;
        step();
        pc_src = 1'b0;
        n_tests++; if (flush !== 1'b1 || req !== 1'b1 || addr !== 32'h104 || valid !== 1'b0) begin
            n_fail++; $display("FAIL squash_enter got f=%h req=%h addr=%h v=%h want 1/1/104/0", flush, req, addr, valid); end
        step();
        n_tests++; if (flush !== 1'b0 || req !== 1'b1 || addr !== 32'h104) begin
            n_fail++; $display("FAIL squash_hold got f=%h req=%h addr=%h want 0/1/104", flush, req, addr); end
        pc_src = 1'b1; tgt = 32'h300;
        step();
        pc_src = 1'b0;
        n_tests++; if (flush !== 1'b1 || req !== 1'b1 || addr !== 32'h104) begin
            n_fail++; $display("FAIL squash_redir2 got f=%h req=%h addr=%h want 1/1/104", flush, req, addr); end
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h300) begin
            n_fail++; $display("FAIL squash_ack got v=%h req=%h addr=%h want 0/1/300", valid, req, addr); end
        ack = 1'b1; rdata = 32'h3333_0300;
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b1 || instr !== 32'h3333_0300 || instr_pc !== 32'h300) begin
            n_fail++; $display("FAIL squash_fetch got v=%h i=%h pc=%h want 1/33330300/300", valid, instr, instr_pc); end
        step();
    endtask

    // Redirect in the same cycle as an ack: data dropped, new target fetched immediately.
    task automatic test_redirect_with_ack();
        pc_src = 1'b1; tgt = 32'h400; ack = 1'b1; rdata = 32'h0000_0BAD;
        step();
        pc_src = 1'b0; ack = 1'b0;
        n_tests++; if (flush !== 1'b1 || valid !== 1'b0 || req !== 1'b1 || addr !== 32'h400) begin
            n_fail++; $display("FAIL redir_ack got f=%h v=%h req=%h addr=%h want 1/0/1/400", flush, valid, req, addr); end
    endtask

    // Stall holds an outstanding request and blocks the next launch only.
    task automatic test_stall();
        stall = 1'b1;
        step();
        n_tests++; if (req !== 1'b1 || addr !== 32'h400) begin
            n_fail++; $display("FAIL stall_keep got req=%h addr=%h want 1/400", req, addr); end
        ack = 1'b1; rdata = 32'h5555_0400;
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b1 || instr_pc !== 32'h400) begin
            n_fail++; $display("FAIL stall_data got v=%h pc=%h want 1/400", valid, instr_pc); end
        step(); step();
        n_tests++; if (valid !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle got v=%h req=%h want 0/0", valid, req); end
        stall = 1'b0;
        step();
        n_tests++; if (req !== 1'b1 || addr !== 32'h404) begin
            n_fail++; $display("FAIL stall_release got req=%h addr=%h want 1/404", req, addr); end
    endtask

    task automatic test_wrap();
        pc_src = 1'b1; tgt = 32'hFFFF_FFFC; ack = 1'b1; rdata = 32'h0;
        step();
        pc_src = 1'b0;
        rdata = 32'h4444_FFFC;
        n_tests++; if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_req got req=%h addr=%h want 1/fffffffc", req, addr); end
        step();
        ack = 1'b0;
        n_tests++; if (valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h4444_FFFC) begin
            n_fail++; $display("FAIL wrap_data got v=%h pc=%h i=%h", valid, instr_pc, instr); end
        step();
        n_tests++; if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next got req=%h addr=%h want 1/0", req, addr); end
    endtask

    // Reset while in SQUASH abandons the request and restarts at RESET_PC.
    task automatic test_reset_squash();
        pc_src = 1'b1; tgt = 32'h500;
        step();
        pc_src = 1'b0;
        rst_n = 1'b0;
        step();
        n_tests++; if (req !== 1'b0 || addr !== 32'h0 || valid !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL rst_squash got req=%h addr=%h v=%h f=%h want 0/0/0/0", req, addr, valid, flush); end
        rst_n = 1'b1;
        step();
        n_tests++; if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_restart got req=%h addr=%h want 1/0", req, addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_redirect_hold();
        test_redirect_squash();
        test_redirect_with_ack();
        test_stall();
        test_wrap();
        test_reset_squash();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
